// File: rtl/approx_adder_pkg.sv
// ============================================================================
// Module : approx_adder_pkg
// Brief  : Approximate full-adder cell equations and sizing helpers.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package approx_adder_pkg;

    localparam int DEFAULT_W = 16;

    function automatic logic approx_fa_s(input logic x, input logic y, input logic cin);
        return (~x & ~y) | (~x & y & ~cin) | (x & cin);
    endfunction

    function automatic logic approx_fa_c(input logic x, input logic y, input logic cin);
        // Carry ignores cin by construction; cin is kept for a uniform cell signature.
        return x | y | (cin & 1'b0);
    endfunction

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc_approx_adder_core.sv
// ============================================================================
// Module : rc_approx_adder_core
// Brief  : Ripple-carry adder, APPROX_BITS LSB cells approximate unless exact=1.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rc_approx_adder_core
    import approx_adder_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int APPROX_BITS = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         exact,
    output logic [W:0]   sum
);

    logic [W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic s_exact;
        logic c_exact;

        assign s_exact = a[i] ^ b[i] ^ carry[i];
        assign c_exact = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));

        if (i < APPROX_BITS) begin : g_approx
            assign sum[i]     = exact ? s_exact : approx_fa_s(a[i], b[i], carry[i]);
            assign carry[i+1] = exact ? c_exact : approx_fa_c(a[i], b[i], carry[i]);
        end else begin : g_exact
            assign sum[i]     = s_exact;
            assign carry[i+1] = c_exact;
        end
    end

    assign sum[W] = carry[W];

endmodule

`default_nettype wire

// File: rtl/approx_adder_rr_arbiter.sv
// ============================================================================
// Module : approx_adder_rr_arbiter
// Brief  : Round-robin sharing of one approximate adder with a registered
//          result stage. APPROX_BYPASS_EN adds a per-requester req_exact input.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module approx_adder_rr_arbiter
    import approx_adder_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int APPROX_BITS = 5,
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*W-1:0]            req_a,
    input  logic [NUM_REQ*W-1:0]            req_b,
`ifdef APPROX_BYPASS_EN
    input  logic [NUM_REQ-1:0]              req_exact,
`endif
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [W:0]                      res_sum,
    output logic [id_width(NUM_REQ)-1:0]    res_id,
    output logic [CNT_W-1:0]                op_count
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_found;
    logic            slot_free;
    logic            accept;
    logic            exact_sel;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W:0]      sum_comb;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign slot_free = !res_valid || res_ready;
    assign accept    = grant_found && slot_free;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    assign a_sel = req_a[int'(grant_idx)*W +: W];
    assign b_sel = req_b[int'(grant_idx)*W +: W];

`ifdef APPROX_BYPASS_EN
    assign exact_sel = req_exact[grant_idx];
`else
    assign exact_sel = 1'b0;
`endif

    rc_approx_adder_core #(
        .W           (W),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a     (a_sel),
        .b     (b_sel),
        .exact (exact_sel),
        .sum   (sum_comb)
    );

    // Drain without a new accept clears valid but keeps the last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
            op_count  <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_sum   <= sum_comb;
            res_id    <= grant_idx;
            rr_ptr    <= next_ptr;
            op_count  <= op_count + CNT_W'(1);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_approx_adder_rr_arbiter.sv
// ============================================================================
// Module : tb_approx_adder_rr_arbiter
// Brief  : Directed self-checking bench for approx_adder_rr_arbiter (W=16, 4 req).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_approx_adder_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
`ifdef APPROX_BYPASS_EN
    logic [3:0]  req_exact;
`endif
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_sum;
    logic [1:0]  res_id;
    logic [31:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;

    approx_adder_rr_arbiter #(
        .W(16), .APPROX_BITS(5), .NUM_REQ(4), .CNT_W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef APPROX_BYPASS_EN
        .req_exact (req_exact),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic v, input logic [16:0] s,
                           input logic [1:0] id, input logic [31:0] cnt);
        chk({tag, ".valid"}, 32'(res_valid), 32'(v));
        chk({tag, ".sum"},   32'(res_sum),   32'(s));
        chk({tag, ".id"},    32'(res_id),    32'(id));
        chk({tag, ".count"}, op_count,       cnt);
    endtask

    initial begin
        logic [1:0] exp_id;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
`ifdef APPROX_BYPASS_EN
        req_exact = '0;
`endif
        #2;
        chk_res("reset", 1'b0, 17'h0, 2'd0, 32'd0);
        chk("reset.ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Req 0: 0 + 0 through the approximate LSBs gives 0x1F.
        req_valid = 4'b0001;
        req_a[0*16 +: 16] = 16'h0000;
        req_b[0*16 +: 16] = 16'h0000;
        #1;
        chk("t2.ready", 32'(req_ready), 32'h1);
        step();
        chk_res("t2", 1'b1, 17'h0001F, 2'd0, 32'd1);

        // Req 2 alone; pointer is at 1 so it is the first valid.
        req_valid = 4'b0100;
        req_a[2*16 +: 16] = 16'hFFFF;
        req_b[2*16 +: 16] = 16'h0001;
        #1;
        chk("t3.ready", 32'(req_ready), 32'h4);
        step();
        chk_res("t3", 1'b1, 17'h1001E, 2'd2, 32'd2);

        // Req 3 alone brings the pointer back to 0.
        req_valid = 4'b1000;
        req_a[3*16 +: 16] = 16'h00FF;
        req_b[3*16 +: 16] = 16'h0F00;
        #1;
        chk("t3b.ready", 32'(req_ready), 32'h8);
        step();
        chk_res("t3b", 1'b1, 17'h0101E, 2'd3, 32'd3);

        // All valid: A_i = i<<8, B_i = 0x20 -> sum (i<<8) + 0x3F.
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i << 8);
            req_b[i*16 +: 16] = 16'h0020;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            #1;
            chk("t4.ready", 32'(req_ready), 32'(4'b0001 << exp_id));
            step();
            chk_res("t4", 1'b1, 17'({exp_id, 8'h00}) + 17'h3F, exp_id, 32'(4 + k));
        end

        // Stall with requesters 1 and 3 waiting.
        req_valid = 4'b1010;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5.stall_ready", 32'(req_ready), 32'h0);
            step();
            chk_res("t5.stall", 1'b1, 17'h0003F, 2'd0, 32'd8);
        end
        res_ready = 1'b1;
        #1;
        chk("t5.rel_ready", 32'(req_ready), 32'h2);
        step();
        chk_res("t5.acc1", 1'b1, 17'h0013F, 2'd1, 32'd9);
        chk("t5.next_ready", 32'(req_ready), 32'h8);
        step();
        chk_res("t5.acc3", 1'b1, 17'h0033F, 2'd3, 32'd10);
        req_valid = 4'b0000;
        #1;
        chk("t5.idle_ready", 32'(req_ready), 32'h0);
        step();
        chk_res("t5.drain", 1'b0, 17'h0033F, 2'd3, 32'd10);

        req_a[0*16 +: 16] = 16'hFFFF;
        req_b[0*16 +: 16] = 16'h0001;
`ifdef APPROX_BYPASS_EN
        req_exact = 4'b0001;
        req_valid = 4'b0001;
        step();
        chk_res("t6.exact", 1'b1, 17'h10000, 2'd0, 32'd11);
        req_exact = 4'b0000;
        step();
        chk_res("t6.approx", 1'b1, 17'h1001E, 2'd0, 32'd12);
`else
        req_valid = 4'b0001;
        step();
        chk_res("t6.approx", 1'b1, 17'h1001E, 2'd0, 32'd11);
`endif
        req_valid = 4'b0000;

        // Asynchronous reset between edges while a result is held.
        res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_res("t1.async", 1'b0, 17'h0, 2'd0, 32'd0);
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1110;
        #1;
        chk("t1.ptr_ready", 32'(req_ready), 32'h2);
        req_valid = 4'b1111;
        #1;
        chk("t1.ptr0_ready", 32'(req_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
